// File: rtl/uart_prog_loader.sv
// UART program loader: length-prefixed 8N1 byte stream -> 32-bit little-endian
// word writes at incrementing addresses; busy holds the CPU in reset meanwhile.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte
// DATA  | assembling words and strobing writes
// DONE  | session complete, done held
// ERR   | framing or length error, flag held
module uart_prog_loader #(
  parameter int CLK_FREQ   = 23000000,
  parameter int BAUD       = 128000,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx,
  output logic                  upg_wen,
  output logic [ADDR_WIDTH-1:0] upg_adr,
  output logic [31:0]           upg_dat,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic                  len_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] TMR_BIT  = TW'(DIV - 1);
  localparam logic [TW-1:0] TMR_HALF = TW'(DIV / 2 - 1);
  localparam logic [16:0]   LEN_MAX  = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_DONE, ST_ERR} state_t;

  rx_state_t             r_rx_state;
  state_t                r_state;
  logic                  r_rx_s1, r_rx_s2, r_rx_s3;
  logic [TW-1:0]         r_tmr;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic [7:0]            r_byte;
  logic                  r_byte_vld;
  logic                  r_stop_err;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [1:0]            r_idx;
  logic [23:0]           r_word;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic                  r_busy, r_done, r_ferr, r_lerr;
  logic                  w_fall;
  logic [15:0]           w_len_n;

  assign w_fall  = r_rx_s3 & ~r_rx_s2;
  assign w_len_n = {r_byte, r_len[7:0]};

  // r_rx_s3 only remembers the previous synced level for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_tmr      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_stop_err <= 1'b0;
      if (!r_busy) begin
        r_rx_state <= RX_IDLE;
        r_bit_cnt  <= '0;
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            if (w_fall) begin
              r_tmr      <= TMR_HALF;
              r_rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (r_tmr == '0) begin
              if (r_rx_s2) begin
                r_rx_state <= RX_IDLE;
              end else begin
                r_tmr      <= TMR_BIT;
                r_bit_cnt  <= '0;
                r_rx_state <= RX_BITS;
              end
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          RX_BITS: begin
            if (r_tmr == '0) begin
              r_shift <= {r_rx_s2, r_shift[7:1]};
              r_tmr   <= TMR_BIT;
              if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
              else                   r_bit_cnt  <= r_bit_cnt + 1'b1;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          RX_STOP: begin
            if (r_tmr == '0) begin
              if (r_rx_s2) begin
                r_byte     <= r_shift;
                r_byte_vld <= 1'b1;
              end else begin
                r_stop_err <= 1'b1;
              end
              r_rx_state <= RX_IDLE;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_wen   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_lerr  <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      if (r_stop_err && r_busy) begin
        r_state <= ST_ERR;
        r_busy  <= 1'b0;
        r_ferr  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
              r_state <= ST_LEN0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_ferr  <= 1'b0;
              r_lerr  <= 1'b0;
              r_cnt   <= '0;
              r_idx   <= '0;
            end
          end
          ST_LEN0: begin
            if (r_byte_vld) begin
              r_len[7:0] <= r_byte;
              r_state    <= ST_LEN1;
            end
          end
          ST_LEN1: begin
            if (r_byte_vld) begin
              r_len[15:8] <= r_byte;
              if (w_len_n == 16'd0) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if ({1'b0, w_len_n} > LEN_MAX) begin
                r_state <= ST_ERR;
                r_busy  <= 1'b0;
                r_lerr  <= 1'b1;
              end else begin
                r_idx   <= '0;
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            // r_cnt was already advanced in the cycle that raised the strobe
            if (r_wen) begin
              if (17'(r_cnt) == {1'b0, r_len}) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else if (r_byte_vld) begin
              case (r_idx)
                2'd0: r_word[7:0]   <= r_byte;
                2'd1: r_word[15:8]  <= r_byte;
                2'd2: r_word[23:16] <= r_byte;
                default: begin
                  r_wen <= 1'b1;
                  r_adr <= r_cnt[ADDR_WIDTH-1:0];
                  r_dat <= {r_byte, r_word};
                  r_cnt <= r_cnt + 1'b1;
                end
              endcase
              r_idx <= r_idx + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign upg_wen   = r_wen;
  assign upg_adr   = r_adr;
  assign upg_dat   = r_dat;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_err = r_ferr;
  assign len_err   = r_lerr;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Serial program/data loader. It is the write-side counterpart of the CPU's memory read path. It receives a length-prefixed byte stream on a UART RX line and assembles it into 32-bit little-endian words. Each word goes out as a single-cycle write strobe with an incrementing word address into the instruction or data memory write port. The top level holds the CPU in reset while the loader is busy.

Parameters:
CLK_FREQ, 23000000, clock frequency in Hz
BAUD, 128000, UART bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer, DIV >= 4)
ADDR_WIDTH, 14, word-address width of the target memory

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: begin a load session
rx  in  1  UART receive line (idle high, 8N1, LSB first)
upg_wen  out  1  memory write strobe, one cycle per word
upg_adr  out  ADDR_WIDTH  word address for upg_wen
upg_dat  out  32  word data for upg_wen
busy  out  1  session in progress (LEN0..DATA)
done  out  1  session completed successfully
frame_err  out  1  stop bit sampled low during the session
len_err  out  1  requested word count exceeds 2^ADDR_WIDTH

Behaviour:
- reset low (any time, including mid-byte or mid-session): state=IDLE, the bit counter, byte counter and word counter clear. All outputs are 0, and upg_adr and upg_dat are 0.
- rx passes through a 2-FF synchronizer (2 cycles of latency) before any use.
- UART RX engine:
  - Runs only while busy=1.
  - A falling edge of synced rx starts the engine, which waits DIV/2 clocks and then resamples.
  - If the line is high at that point, the edge is a glitch: return to line-idle with no byte.
  - Otherwise sample 8 data bits at DIV intervals (LSB first), then sample the stop bit after DIV more clocks.
  - Stop bit = 1: a byte is valid (internal one-cycle pulse).
  - Stop bit = 0: the byte is discarded, frame_err is set, and the FSM moves to ERR.
- FSM states:
  - IDLE: start=1 -> LEN0. Clear done, frame_err, len_err and the word counter; set busy=1.
  - LEN0: on a byte -> store N[7:0] -> LEN1.
  - LEN1: on a byte -> N[15:8].
    - N=0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERR with len_err=1.
    - Otherwise -> DATA.
  - DATA: bytes fill word bytes 0..3 (first byte -> [7:0]).
    - On the 4th byte, the next cycle asserts upg_wen=1 for exactly one cycle, with upg_adr = word counter and upg_dat = the assembled word.
    - The word counter then increments and the byte index returns to 0.
    - When the counter reaches N, the FSM moves -> DONE in the cycle after the last strobe.
  - DONE: busy=0, done=1 (held).
  - ERR: busy=0, with the error flag held.
  - In both DONE and ERR, start=1 -> LEN0, starting a new session with the flags cleared.
- start while busy=1 is ignored.
- start while in IDLE, DONE or ERR is honoured.
- Bytes arriving in IDLE, DONE or ERR are ignored; the RX engine is disabled there.
- upg_adr and upg_dat hold their last values between strobes.
- upg_wen is never asserted outside DATA.
- An N with exactly 2^ADDR_WIDTH words is legal; the last address is all-ones and there is no wrap.
- There is no timeout: a stalled session stays busy until reset.
- Back-to-back bytes with no idle time between stop and start bits are handled.
- Latency: the upg_wen strobe occurs at most 2 clocks after the stop-bit sample of the 4th byte.

Test Plan:
(All scenarios use CLK_FREQ=1600000, BAUD=100000, so DIV=16, and ADDR_WIDTH=4.)
1. Basic load:
   - Stimulus: start, then bytes 02 00 78 56 34 12 EF BE AD DE.
   - Required: upg_wen pulses twice, with adr0=0x12345678 and adr1=0xDEADBEEF, each one cycle wide.
   - Then done=1 and busy=0.
2. Zero-length session:
   - Stimulus: start, then bytes 00 00.
   - Required: no upg_wen; done=1 after the second stop bit.
3. Framing error:
   - Stimulus: start, then 01 00, then a byte with stop bit=0.
   - Required: frame_err=1, busy=0, no upg_wen.
   - A new start clears frame_err, and the sequence 01 00 AA BB CC DD then writes adr0=0xDDCCBBAA.
4. Length limits:
   - N=0x0011 -> len_err=1, no writes.
   - N=0x0010 with 64 data bytes -> 16 writes at adr 0..15, then done=1.
5. Glitch and ignored input:
   - A 3-clock low pulse on rx during LEN0 -> no byte is consumed.
   - Bytes sent while in IDLE -> no state change.
   - start pulsed mid-DATA -> ignored; the session completes normally.
6. Mid-session reset:
   - Stimulus: reset=0 after the 2nd data byte of session 1.
   - Required: all outputs 0 immediately, without waiting for a clock edge.
   - After release and a new session 01 00 01 02 03 04: a write of 0x04030201 at adr0; no stale bytes.
